// File: rtl/cpu6502_core.sv
// Multi-cycle 6502-subset core (LDA#/ADC#/LDA abs/STA abs/JMP abs/NOP) with a req/ack memory port.
// Optional single-step gating of opcode fetches when SINGLE_STEP_EN is defined (adds input step).
module cpu6502_core #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0]        HALT_OP  = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        state_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [7:0]        a_o
);
    // state | meaning: FETCH opcode read, OPLO operand lo, OPHI operand hi, READ abs load, WRITE abs store, HALT stopped
    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_OPLO  = 3'd1,
        S_OPHI  = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        op_q, op_d;
    logic [7:0]        lo_q, lo_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              illegal_q, illegal_d;
    logic              done;
    logic              fetch_go;
    logic [8:0]        sum;
    logic [15:0]       ea_full;

`ifdef SINGLE_STEP_EN
    logic step_pend_q, step_pend_d;
    assign fetch_go = step | step_pend_q;
`else
    assign fetch_go = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ea_q      <= '0;
            a_q       <= 8'h00;
            op_q      <= 8'h00;
            lo_q      <= 8'h00;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            illegal_q <= 1'b0;
`ifdef SINGLE_STEP_EN
            step_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ea_q      <= ea_d;
            a_q       <= a_d;
            op_q      <= op_d;
            lo_q      <= lo_d;
            c_q       <= c_d;
            z_q       <= z_d;
            n_q       <= n_d;
            illegal_q <= illegal_d;
`ifdef SINGLE_STEP_EN
            step_pend_q <= step_pend_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ea_d      = ea_q;
        a_d       = a_q;
        op_d      = op_q;
        lo_d      = lo_q;
        c_d       = c_q;
        z_d       = z_q;
        n_d       = n_q;
        illegal_d = 1'b0;
        done      = mem_req & mem_ack;
        sum       = {1'b0, a_q} + {1'b0, mem_rdata} + {8'b0, c_q};
        ea_full   = {mem_rdata, lo_q};
`ifdef SINGLE_STEP_EN
        // The pending step is consumed by the fetch it launched.
        step_pend_d = step_pend_q;
        if (state_q == S_FETCH) begin
            step_pend_d = (step_pend_q | step) & ~done;
        end
`endif
        case (state_q)
            S_FETCH: begin
                if (done) begin
                    pc_d = pc_q + ADDR_W'(1);
                    op_d = mem_rdata;
                    if (mem_rdata == HALT_OP) begin
                        state_d = S_HALT;
                    end else begin
                        case (mem_rdata)
                            OP_LDA_IMM, OP_ADC_IMM, OP_LDA_ABS,
                            OP_STA_ABS, OP_JMP_ABS: state_d = S_OPLO;
                            OP_NOP:                 state_d = S_FETCH;
                            default:                illegal_d = 1'b1;
                        endcase
                    end
                end
            end
            S_OPLO: begin
                if (done) begin
                    pc_d = pc_q + ADDR_W'(1);
                    if (op_q == OP_LDA_IMM) begin
                        a_d     = mem_rdata;
                        z_d     = (mem_rdata == 8'h00);
                        n_d     = mem_rdata[7];
                        state_d = S_FETCH;
                    end else if (op_q == OP_ADC_IMM) begin
                        a_d     = sum[7:0];
                        c_d     = sum[8];
                        z_d     = (sum[7:0] == 8'h00);
                        n_d     = sum[7];
                        state_d = S_FETCH;
                    end else begin
                        lo_d    = mem_rdata;
                        state_d = S_OPHI;
                    end
                end
            end
            S_OPHI: begin
                if (done) begin
                    pc_d = pc_q + ADDR_W'(1);
                    ea_d = ea_full[ADDR_W-1:0];
                    if (op_q == OP_JMP_ABS) begin
                        pc_d    = ea_full[ADDR_W-1:0];
                        state_d = S_FETCH;
                    end else if (op_q == OP_LDA_ABS) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_READ: begin
                if (done) begin
                    a_d     = mem_rdata;
                    z_d     = (mem_rdata == 8'h00);
                    n_d     = mem_rdata[7];
                    state_d = S_FETCH;
                end
            end
            S_WRITE: begin
                if (done) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset gates the request combinationally so an in-flight access is abandoned at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = a_q;
        if (!reset) begin
            case (state_q)
                S_FETCH: mem_req = fetch_go;
                S_OPLO:  mem_req = 1'b1;
                S_OPHI:  mem_req = 1'b1;
                S_READ: begin
                    mem_req  = 1'b1;
                    mem_addr = ea_q;
                end
                S_WRITE: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = ea_q;
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign state_o = state_q;
    assign pc_o    = pc_q;
    assign a_o     = a_q;

endmodule

// File: tb/tb_cpu6502_core.sv
// Bench for cpu6502_core: directed programs plus random programs with random wait states,
// checked against an instruction-level reference model and an expected memory-access trace.
module tb_cpu6502_core;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ack, halted, illegal;
    logic [15:0] mem_addr, pc_o;
    logic [7:0]  mem_wdata, mem_rdata, a_o;
    logic [2:0]  state_o;
`ifdef SINGLE_STEP_EN
    logic        step;
`endif

    cpu6502_core dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .illegal   (illegal),
        .state_o   (state_o),
        .pc_o      (pc_o),
        .a_o       (a_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [7:0]  mm  [0:65535];
    acc_t        obs_q[$];
    acc_t        exp_q[$];
    logic [15:0] exp_pc;
    logic [7:0]  exp_a;
    logic [2:0]  exp_flags;
    int          exp_ill;
    int          checks = 0;
    int          errors = 0;
    int          wait_mode = 0;
    int          waits_total, cycles_active, illegal_cnt, wr_dur;
    bit          stall_en = 1'b0;
    logic [15:0] stall_addr = 16'h0000;
    bit          in_req, ack_prev;
    int          wl, dur;
    acc_t        req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic acc_t mk(input logic [15:0] a, input logic w, input logic [7:0] d);
        acc_t r;
        r.addr = a;
        r.we   = w;
        r.data = d;
        return r;
    endfunction

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        mem[a] = v;
        mm[a]  = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            mm[i]  = 8'h00;
        end
        for (int i = 16'h8000; i < 16'h8100; i++) poke(16'(i), 8'($urandom));
    endtask

    // Instruction-level reference: executes the program in mm and lists every bus access.
    task automatic model_run();
        logic [15:0] pc = 16'h0000;
        logic [15:0] ea;
        logic [7:0]  a = 8'h00, op, d, lo, hi;
        logic        c = 1'b0, z = 1'b0, n = 1'b0;
        logic [8:0]  s;
        exp_q.delete();
        exp_ill = 0;
        for (int k = 0; k < 5000; k++) begin
            op = mm[pc];
            exp_q.push_back(mk(pc, 1'b0, 8'h00));
            pc = pc + 16'd1;
            if (op == 8'h00) break;
            case (op)
                8'hA9, 8'h69: begin
                    d = mm[pc];
                    exp_q.push_back(mk(pc, 1'b0, 8'h00));
                    pc = pc + 16'd1;
                    if (op == 8'hA9) a = d;
                    else begin
                        s = 9'(a) + 9'(d) + 9'(c);
                        c = s[8];
                        a = s[7:0];
                    end
                    z = (a == 8'h00);
                    n = a[7];
                end
                8'hAD, 8'h8D, 8'h4C: begin
                    lo = mm[pc];
                    exp_q.push_back(mk(pc, 1'b0, 8'h00));
                    pc = pc + 16'd1;
                    hi = mm[pc];
                    exp_q.push_back(mk(pc, 1'b0, 8'h00));
                    pc = pc + 16'd1;
                    ea = {hi, lo};
                    if (op == 8'h4C) pc = ea;
                    else if (op == 8'hAD) begin
                        exp_q.push_back(mk(ea, 1'b0, 8'h00));
                        a = mm[ea];
                        z = (a == 8'h00);
                        n = a[7];
                    end else begin
                        exp_q.push_back(mk(ea, 1'b1, a));
                        mm[ea] = a;
                    end
                end
                8'hEA: ;
                default: exp_ill++;
            endcase
        end
        exp_pc    = pc;
        exp_a     = a;
        exp_flags = {c, z, n};
    endtask

    // Memory responder: acks after a chosen number of wait cycles, logs completed accesses.
    initial begin
        in_req = 1'b0; ack_prev = 1'b0; wl = 0; dur = 0;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_req = 1'b0; ack_prev = 1'b0; mem_ack = 1'b0;
            end else begin
                if (ack_prev) begin
                    obs_q.push_back(req);
                    if (req.we) begin
                        mem[req.addr] = req.data;
                        wr_dur = dur;
                    end
                    in_req = 1'b0; ack_prev = 1'b0;
                end
                if (illegal) illegal_cnt++;
                if (mem_req) begin
                    cycles_active++;
                    if (!in_req) begin
                        in_req   = 1'b1;
                        dur      = 0;
                        req.addr = mem_addr;
                        req.we   = mem_we;
                        req.data = mem_we ? mem_wdata : 8'h00;
                        wl = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                        waits_total += wl;
                    end else begin
                        chk("addr_stable", 32'(mem_addr), 32'(req.addr));
                        chk("we_stable", 32'(mem_we), 32'(req.we));
                        if (req.we) chk("wdata_stable", 32'(mem_wdata), 32'(req.data));
                    end
                    dur++;
                    if (wl == 0 && !(stall_en && mem_addr == stall_addr)) begin
                        mem_ack = 1'b1; mem_rdata = mem[mem_addr]; ack_prev = 1'b1;
                    end else begin
                        mem_ack = 1'b0;
                        if (wl > 0) wl--;
                    end
                end else begin
                    mem_ack = (wait_mode < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        #1;
        obs_q.delete();
        waits_total = 0; cycles_active = 0; illegal_cnt = 0; wr_dur = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_prog(input int wmode, input int tsel, input int budget);
        int n = 0;
        wait_mode = wmode;
        model_run();
        do_reset();
        while (!halted && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (tsel == 1 && n == 2) begin
                chk("t1_a_lda", 32'(a_o), 32'h05);
                chk("t1_z_lda", 32'(dut.z_q), 32'h0);
            end
            if (tsel == 1 && n == 4) begin
                chk("t1_a_adc", 32'(a_o), 32'h00);
                chk("t1_cz_adc", 32'({dut.c_q, dut.z_q}), 32'h3);
            end
            if (tsel == 4 && n == 1) begin
                chk("t4_illegal_on", 32'(illegal), 32'h1);
                chk("t4_pc", 32'(pc_o), 32'h1);
                chk("t4_a", 32'(a_o), 32'h0);
            end
            if (tsel == 4 && n == 2) chk("t4_illegal_off", 32'(illegal), 32'h0);
        end
        chk("halt_reached", 32'(halted), 32'h1);
        repeat (2) @(negedge clk);
        chk("acc_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("acc%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk("pc_final", 32'(pc_o), 32'(exp_pc));
        chk("a_final", 32'(a_o), 32'(exp_a));
        chk("flags_czn", 32'({dut.c_q, dut.z_q, dut.n_q}), 32'(exp_flags));
        chk("illegal_cycles", 32'(illegal_cnt), 32'(exp_ill));
        chk("busy_cycles", 32'(cycles_active), 32'(exp_q.size() + waits_total));
        chk("halt_req_low", 32'(mem_req), 32'h0);
        chk("halt_state", 32'(state_o), 32'h5);
    endtask

    task automatic gen_prog();
        int p = 0;
        int k, skip, tgt;
        logic [7:0] ill_ops [3] = '{8'hFF, 8'h02, 8'h13};
        for (int i = 0; i < 20; i++) begin
            k = int'($urandom_range(0, 7));
            case (k)
                0, 1, 7: begin
                    poke(16'(p), (k == 0) ? 8'hA9 : 8'h69);
                    poke(16'(p + 1), 8'($urandom));
                    p += 2;
                end
                2, 3: begin
                    poke(16'(p), (k == 2) ? 8'hAD : 8'h8D);
                    poke(16'(p + 1), 8'($urandom));
                    poke(16'(p + 2), 8'h80);
                    p += 3;
                end
                4: begin poke(16'(p), 8'hEA); p += 1; end
                5: begin poke(16'(p), ill_ops[$urandom_range(0, 2)]); p += 1; end
                default: begin
                    skip = int'($urandom_range(0, 2));
                    tgt  = p + 3 + skip;
                    poke(16'(p), 8'h4C);
                    poke(16'(p + 1), 8'(tgt));
                    poke(16'(p + 2), 8'(tgt >> 8));
                    for (int j = 0; j < skip; j++) poke(16'(p + 3 + j), 8'($urandom));
                    p = tgt;
                end
            endcase
        end
        poke(16'(p), 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
`ifdef SINGLE_STEP_EN
        step = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_state", 32'(state_o), 32'h0);
        chk("rst_pc", 32'(pc_o), 32'h0);
        chk("rst_a", 32'(a_o), 32'h0);

        // Immediate ops with carry out, zero wait.
        clear_mem();
        poke(16'h0, 8'hA9); poke(16'h1, 8'h05); poke(16'h2, 8'h69);
        poke(16'h3, 8'hFB); poke(16'h4, 8'h00);
        run_prog(0, 1, 200);

        // Absolute load/store with three wait cycles per access.
        clear_mem();
        poke(16'h0, 8'hAD); poke(16'h1, 8'h34); poke(16'h2, 8'h12);
        poke(16'h3, 8'h8D); poke(16'h4, 8'h00); poke(16'h5, 8'h20); poke(16'h6, 8'h00);
        poke(16'h1234, 8'h80);
        run_prog(3, 2, 400);
        chk("t2_wr_cycles", 32'(wr_dur), 32'd4);
        chk("t2_mem2000", 32'(mem[16'h2000]), 32'h80);

        // Store HALT over address 0, jump to FFFE and let the PC wrap into it.
        clear_mem();
        poke(16'h0, 8'hA9); poke(16'h1, 8'h00);
        poke(16'h2, 8'h8D); poke(16'h3, 8'h00); poke(16'h4, 8'h00);
        poke(16'h5, 8'h4C); poke(16'h6, 8'hFE); poke(16'h7, 8'hFF);
        poke(16'hFFFE, 8'hEA); poke(16'hFFFF, 8'hEA);
        run_prog(0, 3, 200);

        // Unknown opcode behaves as NOP with a one-cycle flag.
        clear_mem();
        poke(16'h0, 8'hFF); poke(16'h1, 8'h00);
        run_prog(0, 4, 100);

        // Reset while a write is stalled.
        clear_mem();
        poke(16'h0, 8'hA9); poke(16'h1, 8'h77);
        poke(16'h2, 8'h8D); poke(16'h3, 8'h00); poke(16'h4, 8'h20); poke(16'h5, 8'h00);
        poke(16'h2000, 8'h5A);
        stall_en = 1'b1; stall_addr = 16'h2000; wait_mode = 0;
        do_reset();
        n = 0;
        while (state_o != 3'd4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_reach_write", 32'(state_o), 32'h4);
        repeat (2) @(posedge clk);
        #3;
        chk("t5_req_held", 32'(mem_req & mem_we), 32'h1);
        reset = 1'b1;
        #1;
        chk("t5_req_drop", 32'(mem_req), 32'h0);
        chk("t5_we_drop", 32'(mem_we), 32'h0);
        chk("t5_state", 32'(state_o), 32'h0);
        chk("t5_pc", 32'(pc_o), 32'h0);
        chk("t5_a", 32'(a_o), 32'h0);
        repeat (3) @(posedge clk);
        chk("t5_no_write", 32'(mem[16'h2000]), 32'h5A);
        stall_en = 1'b0;

        for (int r = 0; r < 6; r++) begin
            clear_mem();
            gen_prog();
            run_prog(-1, 0, 3000);
        end

`ifdef SINGLE_STEP_EN
        clear_mem();
        poke(16'h0, 8'hEA); poke(16'h1, 8'hEA); poke(16'h2, 8'hEA);
        step = 1'b0;
        wait_mode = 0;
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("ss_idle_req", 32'(mem_req), 32'h0);
        for (int p = 0; p < 2; p++) begin
            @(posedge clk);
            #1 step = 1'b1;
            @(posedge clk);
            #1 step = 1'b0;
            repeat (4) @(posedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        chk("ss_fetches", 32'(obs_q.size()), 32'd2);
        chk("ss_pc", 32'(pc_o), 32'h2);
        chk("ss_req_low", 32'(mem_req), 32'h0);
        chk("ss_state", 32'(state_o), 32'h0);
        step = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu6502_core.md
Name: cpu6502_core

Overview:
- Parametrised successor to the single-cycle fetch datapath: a multi-cycle 6502-subset CPU core with a request/acknowledge memory port that tolerates wait states.
- Contains an internal PC, accumulator A and flags C/Z/N.
- Sits under the board top in place of the discrete pcounter/control/memmux blocks. Drives the external memory wrapper and exposes debug state/PC/A for the LED controllers.

Parameters:
ADDR_W, 16, address width; legal range 9..16; absolute operands are truncated to ADDR_W LSBs.
RESET_PC, 0, PC value loaded on reset; width ADDR_W.
HALT_OP, 8'h00, opcode that enters HALT.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mem_req  out  1  memory request; held until ack
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  memory address; valid while mem_req
mem_wdata  out  8  write data; valid while mem_req && mem_we
mem_rdata  in  8  read data; sampled on the ack cycle
mem_ack  in  1  completes the current request; may be high in the same cycle as mem_req
halted  out  1  core is in HALT
illegal  out  1  one-cycle pulse when an unknown opcode is fetched
state_o  out  3  FSM state: FETCH=0, OPLO=1, OPHI=2, READ=3, WRITE=4, HALT=5
pc_o  out  ADDR_W  current PC
a_o  out  8  accumulator

Behaviour:
- Reset (asynchronous, active-high): state=FETCH, PC=RESET_PC, A=0, C=Z=N=0. Outputs mem_req=0, mem_we=0, illegal=0, halted=0.
- Reset mid-transaction: the request is abandoned immediately and nothing is written.
- Handshake: in every state except HALT, mem_req=1 with addr/we/wdata stable until a rising edge where mem_ack=1. That edge completes the access and advances the FSM. If mem_ack=0, the FSM holds with no register change.
- mem_ack while mem_req=0 is ignored.
- FETCH: read at PC. On ack: PC+=1, latch opcode, decode.
  - LDA# (A9), ADC# (69), LDA abs (AD), STA abs (8D), JMP abs (4C) -> OPLO.
  - NOP (EA) -> FETCH.
  - HALT_OP -> HALT.
  - Any other opcode -> FETCH with illegal pulsed high for exactly the cycle after the ack; treated as NOP.
- OPLO: read at PC. On ack: PC+=1.
  - Immediate ops execute now -> FETCH. LDA#: A=d. ADC#: {C,A}=A+d+C.
  - Abs ops latch the low byte -> OPHI.
- OPHI: read at PC. On ack: PC+=1, form ea={hi,lo}[ADDR_W-1:0].
  - JMP: PC=ea -> FETCH.
  - LDA -> READ.
  - STA -> WRITE.
- READ: read at ea. On ack: A=d -> FETCH.
- WRITE: mem_we=1, addr=ea, wdata=A. On ack -> FETCH.
- Flags: LDA and ADC update Z=(A==0) and N=A[7]. Only ADC updates C. STA, JMP and NOP leave flags unchanged.
- PC arithmetic is modulo 2^ADDR_W; PC=all-ones increments to 0.
- Zero-wait latency: NOP 1 cycle, immediate ops 2, JMP 3, LDA/STA abs 4.
- HALT: mem_req=0, halted=1. Stays in HALT until reset.
- pc_o, a_o and state_o are registered values, updated on the same edge as the internal registers.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined: adds input port step (1 bit). The FSM may leave FETCH (i.e. assert mem_req in FETCH) only in a cycle where step=1 was sampled, or a step pending latch is set. The latch sets on a step pulse while the core is in FETCH and is consumed when the FETCH request is issued. Exactly one instruction executes per step pulse; all non-FETCH states run freely.
- Undefined: no step port; FETCH requests are issued unconditionally.

Test Plan:
- Zero-wait (ack tied 1), memory A9 05 69 FB 00 at 0 -> after 2 cycles A=05, Z=0. After 4 cycles A=00, C=1, Z=1. Then halted=1, mem_req=0, PC=5.
- Memory AD 34 12 8D 00 20 00, mem[1234]=80, ack delayed 3 cycles per access -> A=80, N=1. mem write 80 to 2000 with mem_we=1 held 4 cycles. Addr/wdata stable throughout.
- JMP wrap: ADDR_W=16, RESET_PC=FFFE, memory at FFFE = 4C, 00 at FFFF, 00 at 0000 -> PC wraps to 0 while fetching the operand high byte (operand bytes 00, 4C? no: use FFFE=EA, FFFF=EA, 0000=00) -> PC goes FFFF, 0000, 0001 and halts.
- Opcode FF at 0 -> illegal high exactly 1 cycle, PC=1, A unchanged, next fetch at 1.
- Assert reset during WRITE with ack held low -> mem_req drops in the same cycle, no write seen, state_o=0, PC=RESET_PC.
- SINGLE_STEP_EN: program EA EA EA, step pulsed twice -> exactly 2 opcode fetches, PC=2, core idles in FETCH with mem_req=0.
